trace_mem_ctrl: RTL and testbench

TRACE_MEM_CTRL -- requirements
Module: trace_mem_ctrl

---
 rtl/trace_mem_ctrl.sv | 151 +++++++++++++++
 tb/tb_trace_mem_ctrl.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/trace_mem_ctrl.sv
// rtl/trace_mem_ctrl.sv - trace capture buffer with stream and trigger/post-trigger modes
//
// Purpose: stores logger words in a DEPTH x WIDTH circular buffer. Stream mode
// behaves as a plain FIFO. Trigger mode records continuously, overwriting the
// oldest entry when full, until a trigger arrives. It then captures
// POST_COUNT_I further words and holds the window for readout.
//
// Ports:
//   CLK_I, RST_I                 clock, synchronous active-high reset
//   MODE_I                       0 = trigger, 1 = stream (latched on arm)
//   ENABLE_I                     arm/run (1) or stop (0)
//   TRG_EVENT_I, POST_COUNT_I    trigger pulse and post-trigger word count
//   LOG_VALID_I/LOG_DATA_I/LOG_READY_O   logger write handshake
//   RD_VALID_O/RD_DATA_O/RD_READY_I      oldest-first read handshake
//   COUNT_O, STATE_O, OVERFLOW_O         fill level, FSM state, sticky drop flag
module trace_mem_ctrl #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 64,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             CLK_I,
  input  logic             RST_I,
  input  logic             MODE_I,
  input  logic             ENABLE_I,
  input  logic             TRG_EVENT_I,
  input  logic [AW-1:0]    POST_COUNT_I,
  input  logic             LOG_VALID_I,
  input  logic [WIDTH-1:0] LOG_DATA_I,
  output logic             LOG_READY_O,
  output logic             RD_VALID_O,
  output logic [WIDTH-1:0] RD_DATA_O,
  input  logic             RD_READY_I,
  output logic [AW:0]      COUNT_O,
  output logic [1:0]       STATE_O,
  output logic             OVERFLOW_O
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ARMED = 2'd1,
    S_POST  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  state_t           state_q, state_d;
  logic [AW-1:0]    wptr_q, rptr_q, post_cnt_q;
  logic [AW:0]      count_q;
  logic             mode_q, ovf_q;

  logic log_ready, rd_valid, arm, trig_load, wr, rd, full, empty, overwrite;

  assign full  = (count_q == FULL_CNT);
  assign empty = (count_q == '0);

  always_comb begin
    state_d   = state_q;
    log_ready = 1'b0;
    rd_valid  = 1'b0;
    arm       = 1'b0;
    trig_load = 1'b0;
    case (state_q)
      S_IDLE: begin
        rd_valid = !empty;
        if (ENABLE_I) begin
          arm     = 1'b1;
          state_d = S_ARMED;
        end
      end
      S_ARMED: begin
        if (mode_q) begin
          log_ready = !full;
          rd_valid  = !empty;
        end else begin
          // Trigger mode records unconditionally; reads wait for DONE/IDLE.
          log_ready = 1'b1;
        end
        if (!ENABLE_I) begin
          state_d = S_IDLE;
        end else if (!mode_q && TRG_EVENT_I) begin
          trig_load = 1'b1;
          state_d   = (POST_COUNT_I == '0) ? S_DONE : S_POST;
        end
      end
      S_POST: begin
        log_ready = 1'b1;
        if (!ENABLE_I) begin
          state_d = S_IDLE;
        end else if (LOG_VALID_I && post_cnt_q == AW'(1)) begin
          state_d = S_DONE;
        end
      end
      default: begin
        rd_valid = !empty;
        if (!ENABLE_I) state_d = S_IDLE;
      end
    endcase
  end

  assign wr        = LOG_VALID_I && log_ready;
  assign rd        = rd_valid && RD_READY_I;
  // Only reachable in trigger mode: stream mode deasserts ready when full.
  assign overwrite = wr && full;

  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      state_q    <= S_IDLE;
      wptr_q     <= '0;
      rptr_q     <= '0;
      count_q    <= '0;
      post_cnt_q <= '0;
      mode_q     <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      state_q <= state_d;
      if (arm) begin
        wptr_q  <= '0;
        rptr_q  <= '0;
        count_q <= '0;
        ovf_q   <= 1'b0;
        mode_q  <= MODE_I;
      end else begin
        if (wr) wptr_q <= wptr_q + AW'(1);
        if (rd || overwrite) rptr_q <= rptr_q + AW'(1);
        if (wr && !rd && !full) count_q <= count_q + (AW+1)'(1);
        else if (rd && !wr)     count_q <= count_q - (AW+1)'(1);
        if (state_q == S_ARMED && mode_q && LOG_VALID_I && !log_ready) ovf_q <= 1'b1;
      end
      if (trig_load) begin
        post_cnt_q <= POST_COUNT_I;
      end else if (state_q == S_POST && wr) begin
        post_cnt_q <= post_cnt_q - AW'(1);
      end
    end
  end

  // Array is not reset; pointers and count define which entries are valid.
  always_ff @(posedge CLK_I) begin
    if (wr) mem[wptr_q] <= LOG_DATA_I;
  end

  assign LOG_READY_O = log_ready;
  assign RD_VALID_O  = rd_valid;
  assign RD_DATA_O   = mem[rptr_q];
  assign COUNT_O     = count_q;
  assign STATE_O     = state_q;
  assign OVERFLOW_O  = ovf_q;

endmodule

// File: tb/tb_trace_mem_ctrl.sv
// tb/tb_trace_mem_ctrl.sv - scoreboard bench for trace_mem_ctrl (DEPTH=8, WIDTH=8)
module tb_trace_mem_ctrl;

  localparam int WIDTH = 8;
  localparam int DEPTH = 8;
  localparam int AW    = 3;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             mode = 1'b0;
  logic             enable = 1'b0;
  logic             trg = 1'b0;
  logic [AW-1:0]    post_count = '0;
  logic             log_valid = 1'b0;
  logic [WIDTH-1:0] log_data = '0;
  logic             log_ready;
  logic             rd_valid;
  logic [WIDTH-1:0] rd_data;
  logic             rd_ready = 1'b0;
  logic [AW:0]      count;
  logic [1:0]       state;
  logic             overflow;

  int checks = 0;
  int failures = 0;
  logic [WIDTH-1:0] exp_q[$];

  always #5 clk = ~clk;

  trace_mem_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .CLK_I(clk), .RST_I(rst), .MODE_I(mode), .ENABLE_I(enable),
    .TRG_EVENT_I(trg), .POST_COUNT_I(post_count),
    .LOG_VALID_I(log_valid), .LOG_DATA_I(log_data), .LOG_READY_O(log_ready),
    .RD_VALID_O(rd_valid), .RD_DATA_O(rd_data), .RD_READY_I(rd_ready),
    .COUNT_O(count), .STATE_O(state), .OVERFLOW_O(overflow)
  );

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Offer one word for a single cycle; acc reports whether it was taken.
  task automatic write_word(input logic [WIDTH-1:0] d, input logic t, output logic acc);
    log_valid = 1'b1;
    log_data  = d;
    trg       = t;
    #1;
    acc = log_ready;
    step();
    log_valid = 1'b0;
    trg       = 1'b0;
  endtask

  // Read n words oldest-first, comparing each against the scoreboard.
  task automatic drain(input int n, input string name);
    logic [WIDTH-1:0] e;
    for (int i = 0; i < n; i++) begin
      rd_ready = 1'b1;
      #1;
      checks++;
      if (rd_valid !== 1'b1) begin
        failures++;
        $display("FAIL %s_valid[%0d]: got %b want 1", name, i, rd_valid);
      end else if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL %s_sb_empty[%0d]: got %h want none", name, i, rd_data);
      end else begin
        e = exp_q.pop_front();
        if (rd_data !== e) begin
          failures++;
          $display("FAIL %s_data[%0d]: got %h want %h", name, i, rd_data, e);
        end
      end
      step();
      rd_ready = 1'b0;
    end
  endtask

  task automatic check_status(input string name, input logic [1:0] st, input logic [AW:0] cnt);
    checks++;
    if (state !== st) begin
      failures++;
      $display("FAIL %s_state: got %0d want %0d", name, state, st);
    end
    checks++;
    if (count !== cnt) begin
      failures++;
      $display("FAIL %s_count: got %0d want %0d", name, count, cnt);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    enable = 1'b0;
    step(); step();
    rst = 1'b0;
    #1;
    check_status("reset", 2'd0, 4'd0);
    checks++;
    if ({log_ready, rd_valid, overflow} !== 3'b000) begin
      failures++;
      $display("FAIL reset_flags: got ready/valid/ovf=%b want 000", {log_ready, rd_valid, overflow});
    end
  endtask

  task automatic test_stream_fill();
    logic acc;
    mode = 1'b1;
    enable = 1'b1;
    step();
    mode = 1'b0;
    check_status("stream_arm", 2'd1, 4'd0);
    for (int i = 1; i <= 8; i++) begin
      write_word(WIDTH'(i), 1'b0, acc);
      if (acc) exp_q.push_back(WIDTH'(i));
    end
    check_status("stream_full", 2'd1, 4'd8);
    checks++;
    if (log_ready !== 1'b0) begin
      failures++;
      $display("FAIL stream_full_ready: got %b want 0", log_ready);
    end
    write_word(8'h09, 1'b0, acc);
    checks++;
    if (acc !== 1'b0 || overflow !== 1'b1) begin
      failures++;
      $display("FAIL stream_overflow: got acc=%b ovf=%b want acc=0 ovf=1", acc, overflow);
    end
    drain(8, "stream_drain");
    #1;
    checks++;
    if (rd_valid !== 1'b0 || count !== 4'd0) begin
      failures++;
      $display("FAIL stream_empty: got valid=%b count=%0d want 0/0", rd_valid, count);
    end
  endtask

  task automatic test_stream_simul();
    logic acc;
    logic [WIDTH-1:0] e;
    for (int i = 0; i < 3; i++) begin
      write_word(WIDTH'(8'h10 + i), 1'b0, acc);
      if (acc) exp_q.push_back(WIDTH'(8'h10 + i));
    end
    check_status("simul_pre", 2'd1, 4'd3);
    log_valid = 1'b1;
    log_data  = 8'h13;
    rd_ready  = 1'b1;
    #1;
    e = (exp_q.size() != 0) ? exp_q.pop_front() : 8'hxx;
    checks++;
    if (rd_valid !== 1'b1 || log_ready !== 1'b1 || rd_data !== e) begin
      failures++;
      $display("FAIL simul_handshake: got v=%b r=%b d=%h want 1/1/%h", rd_valid, log_ready, rd_data, e);
    end
    if (log_ready) exp_q.push_back(8'h13);
    step();
    log_valid = 1'b0;
    rd_ready  = 1'b0;
    check_status("simul_post", 2'd1, 4'd3);
    drain(3, "simul_drain");
    checks++;
    if (overflow !== 1'b1) begin
      failures++;
      $display("FAIL overflow_sticky: got %b want 1", overflow);
    end
    enable = 1'b0;
    step();
    check_status("stream_stop", 2'd0, 4'd0);
  endtask

  task automatic test_trigger_post();
    logic acc;
    int naccept;
    naccept = 0;
    mode = 1'b0;
    enable = 1'b1;
    post_count = 3'd3;
    step();
    check_status("trig_arm", 2'd1, 4'd0);
    checks++;
    if (overflow !== 1'b0) begin
      failures++;
      $display("FAIL trig_arm_ovf: got %b want 0", overflow);
    end
    for (int i = 1; i <= 20; i++) begin
      write_word(WIDTH'(i), (i == 12), acc);
      if (acc) naccept++;
      if (i == 10) begin
        checks++;
        if (rd_valid !== 1'b0 || log_ready !== 1'b1) begin
          failures++;
          $display("FAIL trig_armed_flags: got valid=%b ready=%b want 0/1", rd_valid, log_ready);
        end
      end
      if (i == 12) check_status("trig_post", 2'd2, 4'd8);
    end
    checks++;
    if (naccept != 15) begin
      failures++;
      $display("FAIL trig_accepted: got %0d want 15", naccept);
    end
    check_status("trig_done", 2'd3, 4'd8);
    for (int i = 8; i <= 15; i++) exp_q.push_back(WIDTH'(i));
    trg = 1'b1;
    drain(8, "trig_drain");
    trg = 1'b0;
    check_status("trig_drained", 2'd3, 4'd0);
    enable = 1'b0;
    step();
  endtask

  task automatic test_post_zero();
    logic acc;
    enable = 1'b1;
    post_count = 3'd0;
    step();
    for (int i = 1; i <= 5; i++) begin
      write_word(WIDTH'(i), (i == 5), acc);
      if (acc) exp_q.push_back(WIDTH'(i));
    end
    check_status("pz_done", 2'd3, 4'd5);
    write_word(8'h66, 1'b0, acc);
    checks++;
    if (acc !== 1'b0) begin
      failures++;
      $display("FAIL pz_no_write: got ready=%b want 0", acc);
    end
    drain(5, "pz_drain");
    enable = 1'b0;
    step();
  endtask

  task automatic test_reset_mid_post();
    logic acc;
    enable = 1'b1;
    post_count = 3'd7;
    step();
    for (int i = 1; i <= 9; i++) write_word(WIDTH'(i), (i == 9), acc);
    check_status("rp_post", 2'd2, 4'd8);
    rst = 1'b1;
    enable = 1'b0;
    log_valid = 1'b1;
    step();
    rst = 1'b0;
    log_valid = 1'b0;
    #1;
    check_status("rp_after", 2'd0, 4'd0);
    checks++;
    if (rd_valid !== 1'b0 || log_ready !== 1'b0) begin
      failures++;
      $display("FAIL rp_flags: got valid=%b ready=%b want 0/0", rd_valid, log_ready);
    end
  endtask

  task automatic test_disable();
    logic acc;
    mode = 1'b0;
    enable = 1'b1;
    step();
    for (int i = 1; i <= 4; i++) begin
      if (i == 2) mode = 1'b1;
      write_word(WIDTH'(i), 1'b0, acc);
      if (acc) exp_q.push_back(WIDTH'(i));
    end
    checks++;
    if (log_ready !== 1'b1 || rd_valid !== 1'b0) begin
      failures++;
      $display("FAIL dis_mode_ignored: got ready=%b valid=%b want 1/0", log_ready, rd_valid);
    end
    enable = 1'b0;
    step();
    check_status("dis_idle", 2'd0, 4'd4);
    checks++;
    if (log_ready !== 1'b0) begin
      failures++;
      $display("FAIL dis_ready: got %b want 0", log_ready);
    end
    drain(4, "dis_drain");
    mode = 1'b0;
  endtask

  initial begin
    test_reset();
    test_stream_fill();
    test_stream_simul();
    test_trigger_post();
    test_post_zero();
    test_reset_mid_post();
    test_disable();
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL sb_leftover: got %0d want 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
